// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
//   state_e   : controller state encoding (IDLE, ADD, DONE)
//   NIBBLE_W  : width of the shared adder datapath
//   idx_width : width of the nibble index counter, at least 1 bit
package serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple adder built from a chain of full adders.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum (mod 16)
//   cout : carry out of bit 3
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder controller: one shared 4-bit adder adds two
// NIBBLES-nibble operands LS nibble first, chaining carry through a register.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, sampled only in IDLE
//   a, b, cin    : operands and initial carry, latched on accepted start
//   busy         : high while nibbles are being added
//   done         : one-cycle pulse when sum/cout are new
//   sum, cout    : result, held between operations
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [NIBBLE_W-1:0] add_s;
  logic                add_cout;
  logic [W-1:0]        acc_shift;

  nibble_adder u_nibble_adder (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  // New nibble enters at the top so the LS nibble lands at the bottom after
  // NIBBLES shifts.
  if (NIBBLES == 1) begin : g_acc_single
    assign acc_shift = add_s;
  end else begin : g_acc_multi
    assign acc_shift = {add_s, acc_q[W-1:NIBBLE_W]};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      ADD: begin
        acc_d   = acc_shift;
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        carry_d = add_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = DONE;
          sum_d   = acc_shift;
          cout_d  = add_cout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        cin1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; a = 0; b = 0; cin = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    tick(); tick();
    checks++;
    if ({busy, done, sum, cout} !== 19'd0) begin
      failures++;
      $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b, want all zero",
               busy, done, sum, cout);
    end
    checks++;
    if ({busy1, done1, sum1, cout1} !== 7'd0) begin
      failures++;
      $display("FAIL reset1: busy=%b done=%b sum=%h cout=%b, want all zero",
               busy1, done1, sum1, cout1);
    end
    reset = 1'b0;
    tick();
  endtask

  // One pulsed-start operation with full cycle-by-cycle timing check.
  task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                        input logic vcin, input logic [15:0] exp_sum, input logic exp_cout);
    a = va; b = vb; cin = vcin; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hdead; b = 16'hbeef; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s busy%0d: busy=%b done=%b, want busy=1 done=0", name, i, busy, done);
      end
      if (i < 3) tick();
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== exp_sum || cout !== exp_cout) begin
      failures++;
      $display("FAIL %s result: done=%b busy=%b sum=%h cout=%b, want done=1 busy=0 sum=%h cout=%b",
               name, done, busy, sum, cout, exp_sum, exp_cout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== exp_sum || cout !== exp_cout) begin
      failures++;
      $display("FAIL %s hold: done=%b busy=%b sum=%h cout=%b, want done=0 busy=0 sum=%h cout=%b",
               name, done, busy, sum, cout, exp_sum, exp_cout);
    end
  endtask

  task automatic test_basic();
    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
  endtask

  task automatic test_carry();
    run_op("ripple", 16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("allones", 16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1);
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    a = 16'h00ff; b = 16'h0001; cin = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (sum !== 16'h0100 || cout !== 1'b0) begin
          failures++;
          $display("FAIL ignore sum: sum=%h cout=%b, want 0100 0", sum, cout);
        end
      end
      tick();
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL ignore pulses: got %0d done pulses, want 1", ndone);
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    a = 16'h0123; b = 16'h0456; cin = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      failures++;
      $display("FAIL abort: busy=%b done=%b sum=%h cout=%b, want 0 0 0000 0",
               busy, done, sum, cout);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort quiet: %0d cycles with busy/done, want 0", ndone);
    end
    run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
  endtask

  task automatic test_reset_vs_start();
    a = 16'h0001; b = 16'h0001; start = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || sum !== 16'h0000) begin
      failures++;
      $display("FAIL reset_start: busy=%b sum=%h, want busy=0 sum=0000", busy, sum);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start later: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int last = 0;
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if ((ndone == 1 && t != 5) || (ndone > 1 && t - last != 6)) begin
          failures++;
          $display("FAIL b2b spacing: done at cycle %0d (prev %0d), want 5 then every 6", t, last);
        end
        last = t;
      end
      if (ndone > 0) begin
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
          failures++;
          $display("FAIL b2b value cycle %0d: sum=%h cout=%b, want 0000 1", t, sum, cout);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL b2b count: got %0d done pulses, want 3", ndone);
    end
    tick(); tick();
  endtask

  task automatic test_single_nibble();
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL n1 busy: busy=%b done=%b, want 1 0", busy1, done1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 4'h2 || cout1 !== 1'b1) begin
      failures++;
      $display("FAIL n1 result: done=%b busy=%b sum=%h cout=%b, want 1 0 2 1",
               done1, busy1, sum1, cout1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0 || sum1 !== 4'h2) begin
      failures++;
      $display("FAIL n1 hold: done=%b sum=%h, want 0 2", done1, sum1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_reset_vs_start();
    test_single_nibble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
